// File: rtl/tank_pkg.sv
// Shared types and helpers for the tank controller.
//   tank_state_t : life-cycle state (ALIVE / DEAD / OVER)
//   drv_t        : drive command handed to tank_motion
//   KEY_*_DEF    : default USB keycode bindings
//   sm_step()    : sign-magnitude trig sample -> signed 11-bit pixel step
package tank_pkg;

  typedef enum logic [1:0] {ALIVE, DEAD, OVER} tank_state_t;
  typedef enum logic [1:0] {DRV_NONE, DRV_FWD, DRV_BACK} drv_t;

  localparam logic [7:0] KEY_FWD_DEF   = 8'h52;
  localparam logic [7:0] KEY_BACK_DEF  = 8'h51;
  localparam logic [7:0] KEY_LEFT_DEF  = 8'h50;
  localparam logic [7:0] KEY_RIGHT_DEF = 8'h4F;
  localparam logic [7:0] KEY_FIRE_DEF  = 8'h2C;

  // (speed * |trig|) >> 7, sign from bit 7. A negative zero collapses to 0
  // naturally since -0 == 0.
  function automatic logic signed [10:0] sm_step(input logic [6:0] speed,
                                                 input logic [7:0] sm8);
    logic [13:0] prod;
    logic [10:0] mag;
    prod = {7'd0, speed} * {7'd0, sm8[6:0]};
    mag  = 11'(prod >> 7);
    return sm8[7] ? -$signed(mag) : $signed(mag);
  endfunction

endpackage

// File: rtl/tank_ctrl_if.sv
// Player-side bus of one tank_ctrl instance.
//   keycode/sin/cos/hit     : inputs to the tank (driven by master)
//   BallX/BallY/BallS/Angle : sprite position, size and heading
//   ShootBullet/Alive/Lives : bullet spawn pulse and life status
interface tank_ctrl_if;
  logic [31:0] keycode;
  logic [7:0]  sin;
  logic [7:0]  cos;
  logic        hit;
  logic [9:0]  BallX;
  logic [9:0]  BallY;
  logic [9:0]  BallS;
  logic [5:0]  Angle;
  logic        ShootBullet;
  logic        Alive;
  logic [2:0]  Lives;

  modport master (output keycode, sin, cos, hit,
                  input  BallX, BallY, BallS, Angle, ShootBullet, Alive, Lives);
  modport slave  (input  keycode, sin, cos, hit,
                  output BallX, BallY, BallS, Angle, ShootBullet, Alive, Lives);
endinterface

// File: rtl/tank_motion.sv
// Combinational next-position for one tank.
//   x, y     : current centre
//   sin, cos : sign-magnitude Q0.7 trig for the current heading
//   drv      : FWD / BACK / NONE
//   nx, ny   : next centre, clamped so the sprite stays inside the arena
module tank_motion
  import tank_pkg::*;
#(
  parameter int X_MIN = 0,
  parameter int X_MAX = 639,
  parameter int Y_MIN = 0,
  parameter int Y_MAX = 479,
  parameter int SIZE  = 10,
  parameter int SPEED = 8
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [7:0] sin,
  input  logic [7:0] cos,
  input  drv_t       drv,
  output logic [9:0] nx,
  output logic [9:0] ny
);
  localparam logic signed [10:0] XLO = 11'(X_MIN + SIZE);
  localparam logic signed [10:0] XHI = 11'(X_MAX - SIZE);
  localparam logic signed [10:0] YLO = 11'(Y_MIN + SIZE);
  localparam logic signed [10:0] YHI = 11'(Y_MAX - SIZE);

  logic signed [10:0] sx, sy, tx, ty;

  // Signed 11-bit arithmetic so a step past 0 clamps instead of wrapping.
  // Screen Y grows downward, hence Y moves against sin.
  always_comb begin
    sx = sm_step(7'(SPEED), cos);
    sy = sm_step(7'(SPEED), sin);
    tx = $signed({1'b0, x});
    ty = $signed({1'b0, y});
    case (drv)
      DRV_FWD:  begin tx = tx + sx; ty = ty - sy; end
      DRV_BACK: begin tx = tx - sx; ty = ty + sy; end
      default:  ;
    endcase
    if (tx < XLO)      tx = XLO;
    else if (tx > XHI) tx = XHI;
    if (ty < YLO)      ty = YLO;
    else if (ty > YHI) ty = YHI;
    nx = tx[9:0];
    ny = ty[9:0];
  end
endmodule

// File: rtl/tank_ctrl.sv
// Per-player tank controller, one tick per video frame.
//   frame_clk : frame clock
//   Reset     : async, active-high
//   bus       : tank_ctrl_if.slave (keys, trig, hit in; sprite/fire/life out)
// Decodes keys, moves/turns the tank, rate-limits firing and runs the
// ALIVE -> DEAD -> ALIVE / OVER life cycle.
module tank_ctrl
  import tank_pkg::*;
#(
  parameter int X_CENTER = 300,
  parameter int Y_CENTER = 250,
  parameter int X_MIN = 0,
  parameter int X_MAX = 639,
  parameter int Y_MIN = 0,
  parameter int Y_MAX = 479,
  parameter int SIZE  = 10,
  parameter int SPEED = 8,
  parameter int ANGLE_COUNT = 45,
  parameter logic [7:0] KEY_FWD   = KEY_FWD_DEF,
  parameter logic [7:0] KEY_BACK  = KEY_BACK_DEF,
  parameter logic [7:0] KEY_LEFT  = KEY_LEFT_DEF,
  parameter logic [7:0] KEY_RIGHT = KEY_RIGHT_DEF,
  parameter logic [7:0] KEY_FIRE  = KEY_FIRE_DEF,
  parameter int FIRE_COOLDOWN  = 16,
  parameter int RESPAWN_FRAMES = 60,
  parameter int LIVES = 3
) (
  input  logic        frame_clk,
  input  logic        Reset,
  tank_ctrl_if.slave  bus
);
  localparam int CD_W = $clog2(FIRE_COOLDOWN + 1);
  localparam int RC_W = $clog2(RESPAWN_FRAMES + 1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(FIRE_COOLDOWN);
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RESPAWN_FRAMES - 1);
  localparam logic [5:0]      A_LAST  = 6'(ANGLE_COUNT - 1);
  localparam logic [9:0]      XC = 10'(X_CENTER);
  localparam logic [9:0]      YC = 10'(Y_CENTER);

  tank_state_t     state;
  logic [9:0]      x_q, y_q, nx, ny;
  logic [5:0]      angle_q;
  logic            shoot_q, alive_q, fire_prev_q;
  logic [2:0]      lives_q;
  logic [CD_W-1:0] cd_q;
  logic [RC_W-1:0] rcnt_q;

  logic k_fwd, k_back, k_left, k_right, k_fire;
  logic turn_l, turn_r, fire_go;
  drv_t drv;

  // A key is pressed if it sits in any of the four slots.
  always_comb begin
    k_fwd = 1'b0; k_back = 1'b0; k_left = 1'b0; k_right = 1'b0; k_fire = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.keycode[8*i +: 8] == KEY_FWD)   k_fwd   = 1'b1;
      if (bus.keycode[8*i +: 8] == KEY_BACK)  k_back  = 1'b1;
      if (bus.keycode[8*i +: 8] == KEY_LEFT)  k_left  = 1'b1;
      if (bus.keycode[8*i +: 8] == KEY_RIGHT) k_right = 1'b1;
      if (bus.keycode[8*i +: 8] == KEY_FIRE)  k_fire  = 1'b1;
    end
  end

  // One movement action per frame: FWD > BACK > LEFT > RIGHT.
  always_comb begin
    drv    = k_fwd ? DRV_FWD : (k_back ? DRV_BACK : DRV_NONE);
    turn_l = !k_fwd && !k_back && k_left;
    turn_r = !k_fwd && !k_back && !k_left && k_right;
    // Rising edge of fire, off cooldown; a same-frame hit suppresses it.
    fire_go = k_fire && !fire_prev_q && (cd_q == '0) && !bus.hit;
  end

  tank_motion #(
    .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
    .SIZE(SIZE), .SPEED(SPEED)
  ) u_motion (
    .x(x_q), .y(y_q), .sin(bus.sin), .cos(bus.cos), .drv(drv),
    .nx(nx), .ny(ny)
  );

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state       <= ALIVE;
      x_q         <= XC;
      y_q         <= YC;
      angle_q     <= '0;
      shoot_q     <= 1'b0;
      alive_q     <= 1'b1;
      lives_q     <= 3'(LIVES);
      cd_q        <= '0;
      rcnt_q      <= '0;
      fire_prev_q <= 1'b0;
    end else begin
      shoot_q <= 1'b0;
      if (state != OVER) fire_prev_q <= k_fire;
      case (state)
        ALIVE: begin
          if (bus.hit) begin
            alive_q <= 1'b0;
            if (lives_q > 3'd1) begin
              state   <= DEAD;
              lives_q <= lives_q - 3'd1;
              rcnt_q  <= RC_LOAD;
            end else begin
              state   <= OVER;
              lives_q <= '0;
            end
          end else begin
            x_q <= nx;
            y_q <= ny;
            if (turn_l)      angle_q <= (angle_q == A_LAST) ? '0 : angle_q + 6'd1;
            else if (turn_r) angle_q <= (angle_q == '0) ? A_LAST : angle_q - 6'd1;
            if (fire_go) begin
              shoot_q <= 1'b1;
              cd_q    <= CD_LOAD;
            end else if (cd_q != '0) begin
              cd_q <= cd_q - 1'b1;
            end
          end
        end
        DEAD: begin
          if (rcnt_q == '0) begin
            state   <= ALIVE;
            alive_q <= 1'b1;
            x_q     <= XC;
            y_q     <= YC;
            angle_q <= '0;
            cd_q    <= '0;
          end else begin
            rcnt_q <= rcnt_q - 1'b1;
          end
        end
        default: ;  // OVER: frozen until Reset
      endcase
    end
  end

  assign bus.BallX       = x_q;
  assign bus.BallY       = y_q;
  assign bus.BallS       = 10'(SIZE);
  assign bus.Angle       = angle_q;
  assign bus.ShootBullet = shoot_q;
  assign bus.Alive       = alive_q;
  assign bus.Lives       = lives_q;
endmodule
